lcd_bus_receiver: RTL and testbench

Receive-side model of the character-LCD write bus driven by the LCD driver module. It watches `lcd_rs`, `lcd_w`, `lcd_e` and the 4-bit data bus, follows the 4-bit initialisation handshake, and reassembles nibbles into bytes. It executes the HD44780 subset the driver uses and keeps a 2×16 shadow of the display as `line_1`/`line_2`. It is the responder end of the LCD interface, used in simulation benches and as an on-chip loopback checker.

---
 rtl/lcd_bus_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// ==========================================================================
// lcd_bus_receiver : HD44780 4-bit write-bus responder with 2x16 DDRAM shadow
// Revision 1.0
// ==========================================================================
module lcd_bus_receiver #(
  parameter bit         SKIP_INIT = 1'b0,
  parameter logic [7:0] BLANK     = 8'h20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lcd_rs,
  input  logic         lcd_w,
  input  logic         lcd_e,
  input  logic [3:0]   lcd_data,
  output logic [127:0] line_1,
  output logic [127:0] line_2,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic [6:0]   cursor,
  output logic         four_bit,
  output logic         sync_err
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_e_q;
  logic         r_rs_q;
  logic         r_w_q;
  logic [3:0]   r_data_q;

  logic [3:0]   r_upper;
  logic         r_upper_rs;
  logic [6:0]   r_cursor;
  logic [7:0]   r_byte_out;
  logic         r_byte_rs;
  logic         r_byte_valid;
  logic         r_sync_err;
  logic         r_four_bit;
  logic [127:0] r_line_1;
  logic [127:0] r_line_2;

  logic         w_take;
  logic         w_set_four;
  logic         w_load_upper;
  logic         w_exec;
  logic [7:0]   w_byte;
  logic         w_sync;
  logic [6:0]   w_cursor_inc;
  logic [6:0]   w_cursor_nxt;
  logic         w_clear;
  logic         w_wr_1;
  logic         w_wr_2;
  logic [6:0]   w_cell_lsb;

  // Falling edge of the enable strobe; read strobes are dropped here.
  assign w_take = r_e_q & ~lcd_e & ~r_w_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_e_q    <= 1'b0;
      r_rs_q   <= 1'b0;
      r_w_q    <= 1'b0;
      r_data_q <= 4'h0;
    end else begin
      r_e_q    <= lcd_e;
      r_rs_q   <= lcd_rs;
      r_w_q    <= lcd_w;
      r_data_q <= lcd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= SKIP_INIT ? ST_HI : ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_set_four   = 1'b0;
    w_load_upper = 1'b0;
    w_exec       = 1'b0;
    if (w_take) begin
      case (r_state)
        ST_INIT: begin
          if (r_data_q == 4'h2) begin
            w_state_nxt = ST_HI;
            w_set_four  = 1'b1;
          end
        end
        ST_HI: begin
          w_load_upper = 1'b1;
          w_state_nxt  = ST_LO;
        end
        ST_LO: begin
          w_exec      = 1'b1;
          w_state_nxt = ST_HI;
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  assign w_byte = {r_upper, r_data_q};
  assign w_sync = r_upper_rs ^ r_rs_q;

  // Row 0 ends at 0x27 and row 1 at 0x67; each wraps to the other row's start.
  always_comb begin
    case (r_cursor)
      7'h27:   w_cursor_inc = 7'h40;
      7'h67:   w_cursor_inc = 7'h00;
      default: w_cursor_inc = r_cursor + 7'd1;
    endcase
  end

  always_comb begin
    w_cursor_nxt = r_cursor;
    w_clear      = 1'b0;
    w_wr_1       = 1'b0;
    w_wr_2       = 1'b0;
    if (r_upper_rs) begin
      w_wr_1       = (r_cursor[6:4] == 3'b000);
      w_wr_2       = (r_cursor[6:4] == 3'b100);
      w_cursor_nxt = w_cursor_inc;
    end else if (w_byte == 8'h01) begin
      w_clear      = 1'b1;
      w_cursor_nxt = 7'h00;
    end else if (w_byte[7:1] == 7'b0000001) begin
      w_cursor_nxt = 7'h00;
    end else if (w_byte[7]) begin
      w_cursor_nxt = w_byte[6:0];
    end
  end

  // Column 0 occupies the top byte, so the slice base is (15-col)*8.
  assign w_cell_lsb = {~r_cursor[3:0], 3'b000};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_four_bit   <= SKIP_INIT;
      r_upper      <= 4'h0;
      r_upper_rs   <= 1'b0;
      r_cursor     <= 7'h00;
      r_byte_out   <= 8'h00;
      r_byte_rs    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_byte_valid <= w_exec;
      r_sync_err   <= w_exec & w_sync;
      if (w_set_four) begin
        r_four_bit <= 1'b1;
      end
      if (w_load_upper) begin
        r_upper    <= r_data_q;
        r_upper_rs <= r_rs_q;
      end
      if (w_exec) begin
        r_byte_out <= w_byte;
        r_byte_rs  <= r_upper_rs;
        r_cursor   <= w_cursor_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_line_1 <= {16{BLANK}};
      r_line_2 <= {16{BLANK}};
    end else if (w_exec) begin
      if (w_clear) begin
        r_line_1 <= {16{BLANK}};
        r_line_2 <= {16{BLANK}};
      end
      if (w_wr_1) begin
        r_line_1[w_cell_lsb +: 8] <= w_byte;
      end
      if (w_wr_2) begin
        r_line_2[w_cell_lsb +: 8] <= w_byte;
      end
    end
  end

  assign line_1     = r_line_1;
  assign line_2     = r_line_2;
  assign byte_valid = r_byte_valid;
  assign byte_out   = r_byte_out;
  assign byte_rs    = r_byte_rs;
  assign cursor     = r_cursor;
  assign four_bit   = r_four_bit;
  assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// ==========================================================================
// tb_lcd_bus_receiver : directed and randomized bench with byte-level model
// Revision 1.2
// ==========================================================================
module tb_lcd_bus_receiver;

    localparam int c_TIMEOUT_CYCLES = 200000;

    logic         clk;
    logic         reset;
    logic         lcd_rs;
    logic         lcd_w;
    logic         lcd_e;
    logic [3:0]   lcd_data;
    logic [127:0] line_1;
    logic [127:0] line_2;
    logic         byte_valid;
    logic [7:0]   byte_out;
    logic         byte_rs;
    logic [6:0]   cursor;
    logic         four_bit;
    logic         sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit r_done = 1'b0;

    logic [7:0] m_cells [32];
    logic [6:0] m_cursor;
    bit         m_four;
    bit         m_have;
    logic [3:0] m_up;
    bit         m_up_rs;
    bit         m_valid;
    bit         m_sync;
    logic [7:0] m_last;
    bit         m_last_rs;

    lcd_bus_receiver #(.SKIP_INIT(1'b0), .BLANK(8'h20)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_rs     (lcd_rs),
        .lcd_w      (lcd_w),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data),
        .line_1     (line_1),
        .line_2     (line_2),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_rs    (byte_rs),
        .cursor     (cursor),
        .four_bit   (four_bit),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        repeat (c_TIMEOUT_CYCLES) @(posedge clk);
        if (!r_done) begin
            n_bad++;
            $error("FAIL timeout: stimulus did not complete within %0d cycles", c_TIMEOUT_CYCLES);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic fail(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [127:0] exp_line(input int row);
        logic [127:0] r;
        for (int c = 0; c < 16; c++) r[(15 - c) * 8 +: 8] = m_cells[row * 16 + c];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
        m_cursor  = 7'h00;
        m_four    = 1'b0;
        m_have    = 1'b0;
        m_up      = 4'h0;
        m_up_rs   = 1'b0;
        m_valid   = 1'b0;
        m_sync    = 1'b0;
        m_last    = 8'h00;
        m_last_rs = 1'b0;
    endtask

    task automatic model_exec(input logic [7:0] b, input bit rs);
        if (rs) begin
            if (m_cursor < 7'h10) m_cells[m_cursor] = b;
            else if (m_cursor >= 7'h40 && m_cursor < 7'h50) m_cells[16 + m_cursor - 7'h40] = b;
            if (m_cursor == 7'h27) m_cursor = 7'h40;
            else if (m_cursor == 7'h67) m_cursor = 7'h00;
            else m_cursor = m_cursor + 7'd1;
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
            m_cursor = 7'h00;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_cursor = 7'h00;
        end else if (b >= 8'h80) begin
            m_cursor = b[6:0];
        end
    endtask

    task automatic model_nib(input bit rs, input bit w, input logic [3:0] d);
        m_valid = 1'b0;
        m_sync  = 1'b0;
        if (w) return;
        if (!m_four) begin
            if (d == 4'h2) m_four = 1'b1;
            return;
        end
        if (!m_have) begin
            m_have  = 1'b1;
            m_up    = d;
            m_up_rs = rs;
            return;
        end
        m_have    = 1'b0;
        m_valid   = 1'b1;
        m_sync    = (rs != m_up_rs);
        m_last    = {m_up, d};
        m_last_rs = m_up_rs;
        model_exec(m_last, m_up_rs);
    endtask

    task automatic check_all();
        logic [127:0] e1;
        logic [127:0] e2;
        e1 = exp_line(0);
        e2 = exp_line(1);
        n_cmp++;
        if (byte_valid !== m_valid) fail("byte_valid", byte_valid, m_valid);
        n_cmp++;
        if (sync_err !== m_sync) fail("sync_err", sync_err, m_sync);
        n_cmp++;
        if (byte_out !== m_last) fail("byte_out", byte_out, m_last);
        n_cmp++;
        if (byte_rs !== m_last_rs) fail("byte_rs", byte_rs, m_last_rs);
        n_cmp++;
        if (cursor !== m_cursor) fail("cursor", cursor, m_cursor);
        n_cmp++;
        if (four_bit !== m_four) fail("four_bit", four_bit, m_four);
        n_cmp++;
        if (line_1 !== e1) fail("line_1", line_1, e1);
        n_cmp++;
        if (line_2 !== e2) fail("line_2", line_2, e2);
    endtask

    task automatic nib_t(input bit rs, input bit w, input logic [3:0] d,
                         input int hi, input int lo);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_w    = w;
        lcd_data = d;
        lcd_e    = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        @(posedge clk);
        #1;
        model_nib(rs, w, d);
        check_all();
        repeat (lo - 1) @(posedge clk);
    endtask

    task automatic nib(input bit rs, input bit w, input logic [3:0] d);
        nib_t(rs, w, d, 1, 1);
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b);
        nib(rs, 1'b0, b[7:4]);
        nib(rs, 1'b0, b[3:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        lcd_e = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        check_all();
    endtask

    task automatic do_init();
        nib(1'b0, 1'b0, 4'h3);
        nib(1'b0, 1'b0, 4'h3);
        nib(1'b0, 1'b0, 4'h3);
        nib(1'b0, 1'b0, 4'h2);
    endtask

    initial begin
        logic [7:0] b;
        bit         rs_hi;
        bit         rs_lo;
        reset    = 1'b1;
        lcd_rs   = 1'b0;
        lcd_w    = 1'b0;
        lcd_e    = 1'b0;
        lcd_data = 4'h0;
        model_reset();

        do_reset();
        n_cmp++;
        if (line_1 !== {16{8'h20}}) fail("reset_line_1", line_1, {16{8'h20}});
        n_cmp++;
        if (four_bit !== 1'b0) fail("reset_four_bit", four_bit, 1'b0);
        n_cmp++;
        if (line_2 !== {16{8'h20}} || cursor !== 7'h00 || byte_valid !== 1'b0) begin
            n_bad++;
            $error("FAIL reset state: line_2=%0h cursor=%0h byte_valid=%0b",
                   line_2, cursor, byte_valid);
        end

        do_init();
        n_cmp++;
        if (four_bit !== 1'b1) fail("init_four_bit", four_bit, 1'b1);
        send_byte(1'b0, 8'h28);
        n_cmp++;
        if (byte_out !== 8'h28) fail("fs_byte_out", byte_out, 8'h28);

        send_byte(1'b0, 8'hC0);
        send_byte(1'b1, 8'h48);
        send_byte(1'b1, 8'h69);
        n_cmp++;
        if (line_2[127:112] !== 16'h4869) fail("hi_line_2", line_2[127:112], 16'h4869);
        n_cmp++;
        if (cursor !== 7'h42) fail("hi_cursor", cursor, 7'h42);
        n_cmp++;
        if (line_1 !== {16{8'h20}}) fail("hi_line_1", line_1, {16{8'h20}});

        send_byte(1'b0, 8'hA7);
        send_byte(1'b1, 8'h41);
        n_cmp++;
        if (cursor !== 7'h40) fail("wrap_cursor", cursor, 7'h40);
        send_byte(1'b0, 8'h8F);
        send_byte(1'b1, 8'h5A);
        n_cmp++;
        if (line_1[7:0] !== 8'h5A) fail("z_cell", line_1[7:0], 8'h5A);
        n_cmp++;
        if (cursor !== 7'h10) fail("z_cursor", cursor, 7'h10);

        send_byte(1'b0, 8'h01);
        n_cmp++;
        if (line_1 !== {16{8'h20}}) fail("clr_line_1", line_1, {16{8'h20}});
        n_cmp++;
        if (line_2 !== {16{8'h20}}) fail("clr_line_2", line_2, {16{8'h20}});
        n_cmp++;
        if (cursor !== 7'h00) fail("clr_cursor", cursor, 7'h00);

        nib(1'b1, 1'b0, 4'h4);
        nib(1'b0, 1'b0, 4'h1);
        n_cmp++;
        if (sync_err !== 1'b1) fail("sync_pulse", sync_err, 1'b1);
        n_cmp++;
        if (line_1[127:120] !== 8'h41) fail("sync_as_data", line_1[127:120], 8'h41);
        @(posedge clk);
        #1;
        n_cmp++;
        if (sync_err !== 1'b0) fail("sync_one_cycle", sync_err, 1'b0);

        nib(1'b0, 1'b0, 4'h8);
        do_reset();
        do_init();
        send_byte(1'b0, 8'h85);
        n_cmp++;
        if (byte_out !== 8'h85) fail("midrst_byte", byte_out, 8'h85);
        n_cmp++;
        if (cursor !== 7'h05) fail("midrst_cursor", cursor, 7'h05);

        nib(1'b1, 1'b1, 4'h5);
        nib(1'b0, 1'b1, 4'h2);
        send_byte(1'b1, 8'h51);
        n_cmp++;
        if (line_1[127 - 5 * 8 -: 8] !== 8'h51) fail("rd_ign_cell", line_1[127 - 5 * 8 -: 8], 8'h51);
        n_cmp++;
        if (cursor !== 7'h06) fail("rd_ign_cursor", cursor, 7'h06);

        for (int n = 0; n < 250; n++) begin
            rs_hi = 1'($urandom_range(0, 1));
            rs_lo = ($urandom_range(0, 9) == 0) ? ~rs_hi : rs_hi;
            if (rs_hi) begin
                b = 8'($urandom_range(8'h20, 8'h7E));
            end else begin
                case ($urandom_range(0, 9))
                    0:       b = 8'h01;
                    1:       b = 8'h02 | 8'($urandom_range(0, 1));
                    2:       b = 8'h28;
                    3:       b = 8'h0C;
                    4:       b = 8'h06;
                    5:       b = 8'h80 | 8'($urandom_range(0, 127));
                    6, 7:    b = 8'h80 | 8'($urandom_range(8'h00, 8'h27));
                    default: b = 8'h80 | 8'($urandom_range(8'h40, 8'h67));
                endcase
            end
            if ($urandom_range(0, 11) == 0)
                nib_t(1'($urandom_range(0, 1)), 1'b1, 4'($urandom), 1, 1);
            nib_t(rs_hi, 1'b0, b[7:4], $urandom_range(1, 3), $urandom_range(1, 2));
            nib_t(rs_lo, 1'b0, b[3:0], $urandom_range(1, 3), $urandom_range(1, 2));
        end

        r_done = 1'b1;
        if (n_bad != 0) begin
            $error("FAIL summary: %0d of %0d comparisons mismatched", n_bad, n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
